// File: rtl/dct_pkg.sv
// Shared constants and types for the 8x8 forward/inverse DCT blocks.
// COS_TBL[u][k] = round(2^13 * c(u)/2 * cos((2k+1)u*pi/16)); every entry fits
// a COS_W-bit signed value. Row results carry ROW_FRAC fractional bits.
package dct_pkg;

    localparam int unsigned N        = 8;
    localparam int unsigned PIX_W    = 8;
    localparam int unsigned COEF_W   = 16;
    localparam int unsigned COS_W    = 14;
    localparam int unsigned COS_FRAC = 13;
    localparam int unsigned ROW_FRAC = 4;
    localparam int unsigned ROW_W    = 16;
    localparam int unsigned SHIFT_W  = PIX_W + 1;

    typedef logic [N-1:0][PIX_W-1:0]  pix_row_t;
    typedef logic [N-1:0][ROW_W-1:0]  row_res_t;
    typedef logic [N-1:0][COEF_W-1:0] coef_row_t;

    localparam int COS_TBL [N][N] = '{
        '{ 2896,  2896,  2896,  2896,  2896,  2896,  2896,  2896},
        '{ 4017,  3406,  2276,   799,  -799, -2276, -3406, -4017},
        '{ 3784,  1567, -1567, -3784, -3784, -1567,  1567,  3784},
        '{ 3406,  -799, -4017, -2276,  2276,  4017,   799, -3406},
        '{ 2896, -2896, -2896,  2896,  2896, -2896, -2896,  2896},
        '{ 2276, -4017,   799,  3406, -3406,  -799,  4017, -2276},
        '{ 1567, -3784,  3784, -1567, -1567,  3784, -3784,  1567},
        '{  799, -2276,  3406, -4017,  4017, -3406,  2276,  -799}
    };

endpackage

// File: rtl/dct_ft_matrix_2d_1d.sv
// dct_1d_8: combinational 8-point 1-D DCT as a constant-matrix multiply.
//   i_x  in  8 x IN_W   signed samples, i_x[k] is sample k
//   o_y  out 8 x OUT_W  o_y[u] = round(sum_k COS_TBL[u][k]*i_x[k] / 2^SHIFT)
module dct_1d_8
    import dct_pkg::*;
#(
    parameter int unsigned IN_W  = 9,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 9
) (
    input  logic [N-1:0][IN_W-1:0]  i_x,
    output logic [N-1:0][OUT_W-1:0] o_y
);

    localparam int unsigned ACC_W = IN_W + COS_W + 3;
    // Half an output LSB, added before the arithmetic shift.
    localparam logic signed [ACC_W-1:0] RND =
        {{(ACC_W - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};

    logic signed [ACC_W-1:0] acc;

    always_comb begin
        acc = '0;
        o_y = '0;
        for (int u = 0; u < N; u++) begin
            acc = RND;
            for (int k = 0; k < N; k++) begin
                acc = acc + ACC_W'($signed(i_x[k])) * ACC_W'(COS_TBL[u][k]);
            end
            o_y[u] = OUT_W'(acc >>> SHIFT);
        end
    end

endmodule

// File: rtl/dct_ft_matrix_2d.sv
// dct_ft_matrix_2d: forward 8x8 2-D DCT, row beats of pixels in, row beats of
// signed coefficients out (beat u carries F(u,0..7)), fixed 3-cycle latency
// from the 8th input row to the first output row.
//   clk, rst_n        clock; synchronous reset, active high
//   in_valid/in_data  one row of 8 unsigned pixels, in_data[n] = column n
//   in_sob/eob/sof    start of block, end of block, start of frame
//   out_valid/out_data coefficient row, out_data[v] = F(u,v), two's complement
//   out_sob/eob/sof   sideband on beats 0, 7 and 0
// Optional macro DCT_FT_PROTO_CHECK_EN enables simulation-only protocol asserts.
module dct_ft_matrix_2d
    import dct_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [N-1:0][PIX_W-1:0]   in_data,
    input  logic                      in_sob,
    input  logic                      in_eob,
    input  logic                      in_sof,
    output logic                      out_valid,
    output logic [N-1:0][COEF_W-1:0]  out_data,
    output logic                      out_sob,
    output logic                      out_eob,
    output logic                      out_sof
);

    // ---------------- row stage ----------------
    logic [2:0]                 r_row_cnt;
    logic                       r_wr_bank;
    logic                       r_blk_sof;
    logic [2:0]                 w_row_idx;
    logic [N-1:0][SHIFT_W-1:0]  w_shift;
    row_res_t                   w_row;
    row_res_t                   r_bank [2][N];

    // sob restarts the block; the counter wraps after row 7 on its own
    assign w_row_idx = in_sob ? 3'd0 : r_row_cnt;

    // Level shift to signed: pixel - 128
    always_comb begin
        w_shift = '0;
        for (int n = 0; n < N; n++) begin
            w_shift[n] = SHIFT_W'($signed({1'b0, in_data[n]}) - 9'sd128);
        end
    end

    dct_1d_8 #(
        .IN_W  (SHIFT_W),
        .OUT_W (ROW_W),
        .SHIFT (COS_FRAC - ROW_FRAC)
    ) u_row (
        .i_x (w_shift),
        .o_y (w_row)
    );

    // Transpose buffer, ping-pong per block
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_bank[r_wr_bank][w_row_idx] <= w_row;
        end
    end

    // Completion pipeline: r_cpl at the 8th row, r_cpl2 one cycle later
    logic r_cpl, r_cpl_bank, r_cpl_sof;
    logic r_cpl2, r_cpl2_bank, r_cpl2_sof;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_row_cnt   <= 3'd0;
            r_wr_bank   <= 1'b0;
            r_blk_sof   <= 1'b0;
            r_cpl       <= 1'b0;
            r_cpl_bank  <= 1'b0;
            r_cpl_sof   <= 1'b0;
            r_cpl2      <= 1'b0;
            r_cpl2_bank <= 1'b0;
            r_cpl2_sof  <= 1'b0;
        end else begin
            r_cpl <= 1'b0;
            if (in_valid) begin
                r_row_cnt <= w_row_idx + 3'd1;
                if (w_row_idx == 3'd0) begin
                    r_blk_sof <= in_sof & in_sob;
                end
                if (w_row_idx == 3'd7) begin
                    r_cpl      <= 1'b1;
                    r_cpl_bank <= r_wr_bank;
                    r_cpl_sof  <= r_blk_sof;
                    r_wr_bank  <= ~r_wr_bank;
                end
            end
            r_cpl2      <= r_cpl;
            r_cpl2_bank <= r_cpl_bank;
            r_cpl2_sof  <= r_cpl_sof;
        end
    end

    // ---------------- column stage ----------------
    row_res_t   w_col_in  [N];   // [v][x] = bank[x][v]
    coef_row_t  w_col_out [N];   // [v][u] = F(u,v)
    coef_row_t  r_coef    [N];   // [u][v]

    always_comb begin
        for (int v = 0; v < N; v++) begin
            w_col_in[v] = '0;
            for (int x = 0; x < N; x++) begin
                w_col_in[v][x] = r_bank[r_cpl2_bank][x][v];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_col
        dct_1d_8 #(
            .IN_W  (ROW_W),
            .OUT_W (COEF_W),
            .SHIFT (COS_FRAC + ROW_FRAC)
        ) u_col (
            .i_x (w_col_in[g]),
            .o_y (w_col_out[g])
        );
    end

    // Whole block is captured at once so the next block can reuse the bank
    always_ff @(posedge clk) begin
        if (r_cpl2) begin
            for (int u = 0; u < N; u++) begin
                for (int v = 0; v < N; v++) begin
                    r_coef[u][v] <= w_col_out[v][u];
                end
            end
        end
    end

    // ---------------- output sequencer ----------------
    logic       r_emit;
    logic [2:0] r_u;
    logic       r_emit_sof;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_emit     <= 1'b0;
            r_u        <= 3'd0;
            r_emit_sof <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sob    <= 1'b0;
            out_eob    <= 1'b0;
            out_sof    <= 1'b0;
        end else begin
            out_valid <= r_emit;
            out_sob   <= r_emit && (r_u == 3'd0);
            out_eob   <= r_emit && (r_u == 3'd7);
            out_sof   <= r_emit && (r_u == 3'd0) && r_emit_sof;
            out_data  <= r_emit ? r_coef[r_u] : '0;
            if (r_emit) begin
                r_u <= r_u + 3'd1;
                if (r_u == 3'd7) begin
                    r_emit <= 1'b0;
                end
            end
            // A new block may start on the same edge the last row goes out
            if (r_cpl2) begin
                r_emit     <= 1'b1;
                r_u        <= 3'd0;
                r_emit_sof <= r_cpl2_sof;
            end
        end
    end

`ifdef DCT_FT_PROTO_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n && in_valid) begin
            assert (in_eob == (w_row_idx == 3'd7))
                else $error("dct_ft_matrix_2d: in_eob not on the 8th row beat");
            assert (!(in_sob && (r_row_cnt != 3'd0)))
                else $error("dct_ft_matrix_2d: in_sob discards a partial block");
            assert (!(in_sof && !in_sob))
                else $error("dct_ft_matrix_2d: in_sof without in_sob");
        end
    end
`else
    // eob carries no framing information
    logic w_unused_eob;
    assign w_unused_eob = in_eob;
`endif

endmodule

// File: tb/tb_dct_ft_matrix_2d.sv
`timescale 1ns/1ps
module tb_dct_ft_matrix_2d;

    localparam real PI = 3.14159265358979323846;

    typedef logic [7:0][7:0][7:0] blk_t;   // [row x][column y] pixel

    typedef struct packed {
        int               cyc;
        logic             sob;
        logic             eob;
        logic             sof;
        logic [7:0][15:0] exp;
        blk_t             pix;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic [7:0][7:0]  in_data = '0;
    logic             in_sob = 1'b0;
    logic             in_eob = 1'b0;
    logic             in_sof = 1'b0;
    logic             out_valid;
    logic [7:0][15:0] out_data;
    logic             out_sob;
    logic             out_eob;
    logic             out_sof;

    int    cyc = 0;
    int    n_chk = 0;
    int    n_err = 0;
    bit    chk_en = 1'b0;
    beat_t q[$];
    real   ct [8][8];            // ct[k][u] = cos((2k+1)u*pi/16)
    int    fexp [8][8];          // model result [u][v]
    logic [7:0][15:0] dut_rows [8];
    int    cap_dc = 0;

    dct_ft_matrix_2d dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sob    (in_sob),
        .in_eob    (in_eob),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sob   (out_sob),
        .out_eob   (out_eob),
        .out_sof   (out_sof)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic real cf(input int u);
        return (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    endfunction

    function automatic int rnd(input real a);
        return (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(-a + 0.5);
    endfunction

    // Reference 2-D DCT straight from the definition
    function automatic void model(input blk_t p);
        real acc;
        for (int u = 0; u < 8; u++) begin
            for (int v = 0; v < 8; v++) begin
                acc = 0.0;
                for (int x = 0; x < 8; x++)
                    for (int y = 0; y < 8; y++)
                        acc += (real'(p[x][y]) - 128.0) * ct[x][u] * ct[y][v];
                fexp[u][v] = rnd(0.25 * cf(u) * cf(v) * acc);
            end
        end
    endfunction

    // Inverse DCT of the collected DUT rows; worst pixel deviation from p
    function automatic int idct_err(input blk_t p);
        real acc;
        int  e, worst;
        worst = 0;
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                acc = 0.0;
                for (int u = 0; u < 8; u++)
                    for (int v = 0; v < 8; v++)
                        acc += 0.25 * cf(u) * cf(v) * real'($signed(dut_rows[u][v]))
                               * ct[x][u] * ct[y][v];
                e = rnd(acc + 128.0) - int'(p[x][y]);
                if (e < 0) e = -e;
                if (e > worst) worst = e;
            end
        end
        return worst;
    endfunction

    task automatic check_int(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Per-cycle compare against the scheduled expected beats
    always @(negedge clk) begin : cmp_blk
        beat_t b;
        int    d, rx, worst;
        bit    ok;
        if (chk_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                b = q.pop_front();
                n_chk++; n_err++;
                $display("FAIL beat_missing: beat due at cycle %0d not seen", b.cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                b = q.pop_front();
                n_chk++;
                if ({out_valid, out_sob, out_eob, out_sof} != {1'b1, b.sob, b.eob, b.sof}) begin
                    n_err++;
                    $display("FAIL sideband cyc %0d: got v/sob/eob/sof %b%b%b%b expected 1%b%b%b",
                             cyc, out_valid, out_sob, out_eob, out_sof, b.sob, b.eob, b.sof);
                end
                ok = 1'b1;
                for (int v = 0; v < 8; v++) begin
                    d = int'($signed(out_data[v])) - int'($signed(b.exp[v]));
                    if (d > 1 || d < -1) begin
                        ok = 1'b0;
                        $display("FAIL coef cyc %0d col %0d: got %0d expected %0d +-1",
                                 cyc, v, $signed(out_data[v]), $signed(b.exp[v]));
                    end
                end
                n_chk++;
                if (!ok) n_err++;
                if (b.sob) begin
                    rx = 0;
                    cap_dc = int'($signed(out_data[0]));
                end
                dut_rows[rx & 7] = out_data;
                rx++;
                if (b.eob) begin
                    worst = idct_err(b.pix);
                    n_chk++;
                    if (worst > 2) begin
                        n_err++;
                        $display("FAIL idct_roundtrip: worst pixel error %0d allowed 2", worst);
                    end
                end
            end else begin
                n_chk++;
                if (out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL idle cyc %0d: got out_valid %b expected 0", cyc, out_valid);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive_row(input logic [7:0][7:0] row, input bit sob, input bit eob,
                             input bit sof);
        in_valid = 1'b1; in_data = row; in_sob = sob; in_eob = eob; in_sof = sof;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0;
    endtask

    task automatic push_block(input blk_t p, input bit sof, input int t);
        beat_t b;
        model(p);
        for (int u = 0; u < 8; u++) begin
            b.cyc = t + 3 + u;
            b.sob = (u == 0);
            b.eob = (u == 7);
            b.sof = sof && (u == 0);
            for (int v = 0; v < 8; v++) b.exp[v] = 16'(fexp[u][v]);
            b.pix = p;
            q.push_back(b);
        end
    endtask

    task automatic send_block(input blk_t p, input bit sof, input int max_gap);
        for (int x = 0; x < 8; x++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            drive_row(p[x], x == 0, x == 7, sof && (x == 0));
        end
        push_block(p, sof, cyc);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b1;
        @(posedge clk); #1;
        q.delete();
        if (n > 1) idle(n - 1);
        rst_n = 1'b0;
        check_int("reset_ctrl", int'({out_valid, out_sob, out_eob, out_sof}), 0);
        check_int("reset_data_nonzero", int'(out_data != '0), 0);
    endtask

    function automatic blk_t fill(input logic [7:0] val);
        blk_t p;
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) p[x][y] = val;
        return p;
    endfunction

    function automatic blk_t rand_blk();
        blk_t p;
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) p[x][y] = 8'($urandom_range(1, 255));
        return p;
    endfunction

    initial begin
        blk_t p;
        for (int k = 0; k < 8; k++)
            for (int u = 0; u < 8; u++)
                ct[k][u] = $cos(real'((2 * k + 1) * u) * PI / 16.0);

        // reset
        @(posedge clk); #1;
        chk_en = 1'b1;
        idle(1);
        rst_n = 1'b0;
        check_int("reset_ctrl", int'({out_valid, out_sob, out_eob, out_sof}), 0);
        check_int("reset_data_nonzero", int'(out_data != '0), 0);

        // pin the model with hand-computed values
        model(fill(8'd255));
        check_int("model_dc_255", fexp[0][0], 1016);
        check_int("model_ac_255", fexp[3][5], 0);
        model(fill(8'd1));
        check_int("model_dc_1", fexp[0][0], -1016);
        p = fill(8'd128);
        p[0][0] = 8'd255;
        model(p);
        check_int("model_imp_00", fexp[0][0], 16);
        check_int("model_imp_01", fexp[0][1], 22);
        check_int("model_imp_11", fexp[1][1], 31);

        // directed blocks
        idle(2);
        send_block(fill(8'd128), 1'b1, 0);
        idle(12);
        check_int("dut_dc_128", cap_dc, 0);
        send_block(fill(8'd255), 1'b0, 0);
        idle(12);
        check_int("dut_dc_255", cap_dc, 1016);
        send_block(fill(8'd1), 1'b0, 0);
        idle(12);
        check_int("dut_dc_1", cap_dc, -1016);
        send_block(p, 1'b0, 0);
        idle(12);
        check_int("dut_dc_impulse", cap_dc, 16);

        // back-to-back, sof on the first only
        send_block(rand_blk(), 1'b1, 0);
        send_block(rand_blk(), 1'b0, 0);
        idle(15);

        // partial block discarded by a new sob
        p = rand_blk();
        for (int x = 0; x < 3; x++) drive_row(p[x], x == 0, 1'b0, 1'b0);
        send_block(rand_blk(), 1'b0, 0);
        idle(12);

        // reset during row 4, then a fresh block
        p = rand_blk();
        for (int x = 0; x < 5; x++) drive_row(p[x], x == 0, 1'b0, 1'b0);
        do_reset(2);
        idle(3);
        send_block(rand_blk(), 1'b1, 0);
        idle(12);

        // reset while a block is being emitted
        send_block(rand_blk(), 1'b0, 0);
        idle(5);
        do_reset(2);
        idle(12);
        send_block(rand_blk(), 1'b0, 1);
        idle(12);

        // random blocks with gaps between and within
        for (int i = 0; i < 20; i++) begin
            idle($urandom_range(1, 36));
            send_block(rand_blk(), 1'($urandom_range(0, 1)), 2);
        end
        idle(20);
        check_int("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dct_ft_matrix_2d.md
# dct_ft_matrix_2d

Forward 8×8 two-dimensional DCT for the JPEG encoder datapath. Accepts an image block as eight consecutive row beats of eight unsigned 8-bit pixels and emits eight row beats of eight signed 16-bit DCT coefficients, with block/frame sideband re-aligned to the output. It feeds quantisation and is the exact counterpart of the inverse `dct_it_matrix`; forward followed by inverse must reproduce every pixel within ±2.

## Interface
- No parameters. Block size is fixed at 8×8.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-high reset; the `_n` name is kept from the codebase, and asserted = 1.
- `in_valid`  in  1  one input row beat this cycle.
- `in_data`  in  8×8  packed row; `in_data[n]` is pixel column n, unsigned.
- `in_sob`  in  1  start of block; marks row 0.
- `in_eob`  in  1  end of block; marks row 7.
- `in_sof`  in  1  start of frame; meaningful only with `in_sob`.
- `out_valid`  out  1  one coefficient row beat.
- `out_data`  out  8×16 signed  `out_data[v]` = F(u,v) for output beat u.
- `out_sob`, `out_eob`, `out_sof`  out  1 each  sideband for beats 0, 7 and 0 respectively.

## Operation
- Level shift: s = pixel − 128, giving a signed 9-bit value.
- Transform: F(u,v) = ¼·c(u)·c(v)·ΣxΣy s(x,y)·cos((2x+1)uπ/16)·cos((2y+1)vπ/16), where c(0)=1/√2 and otherwise c=1.
- Accuracy: every output is within ±1 of round-half-away(F). Achieve this with 14-bit cosine constants and at least 4 fractional bits kept in the row results.
- Output range: DC spans −1024..1016, so no saturation is needed.
- Row stage:
  - Each valid beat is 1-D transformed along the row and written into the transpose buffer at index `row_cnt`.
  - `in_sob` forces `row_cnt` to 0 for that beat.
  - `row_cnt` increments on every valid beat.
  - The 8th beat (`row_cnt` = 7) completes the block and hands its buffer to the column stage.
- `in_eob` is not used for framing.
- A new `in_sob` while `row_cnt` ≠ 0 discards the partial block.
- Gaps (`in_valid` = 0) are allowed between and within blocks.
- The transpose buffer is ping-pong, two 8×8 banks. Writing alternates banks per block, so back-to-back blocks stall nothing.
- Column stage: emits coefficient rows u = 0..7 on consecutive cycles.
- Sideband out:
  - `out_sob` = (u = 0); `out_eob` = (u = 7).
  - `out_sof` = the `in_sof` captured on that block's row-0 beat, asserted on u = 0 only.

## Timing
- Reset: all outputs 0; `row_cnt` = 0; bank pointers 0; pending blocks cancelled. Buffer contents need no reset.
- Latency: if the completing (8th) beat is sampled at edge T, output beat u is valid in cycle T+3+u.
- Output has no gaps within a block; `out_valid` = 0 otherwise.
- No backpressure; the producer never exceeds 1 beat/cycle.
- Back-to-back: the earliest next completion is T+8, so its output starts at T+11 and follows the prior block's last beat (T+10) seamlessly.
- Reset mid-block or mid-output: the block is dropped, with no stray beats after reset release.

## Configuration
- `DCT_FT_PROTO_CHECK_EN` defined: simulation-only immediate assertions fire in three cases:
  - `in_eob` does not coincide with the 8th beat;
  - `in_sob` arrives with `row_cnt` ≠ 0;
  - `in_sof` arrives without `in_sob`.
- Undefined: no checks, identical RTL behaviour.

## Structure
- Shared package `dct_pkg`: 8×8 cosine constant table, coefficient width (16), pixel width (8), fraction-bit constant, row/coefficient array typedefs. Used by both the forward and inverse blocks.
- One sub-module, `dct_1d_8`: 8-point 1-D DCT as a constant-matrix multiply. Instantiated for the row stage and the column stage with per-instance input width.

## Test plan
- All pixels 128, one block -> all 64 coefficients 0; `out_sob` on beat 0, `out_eob` on beat 7.
- All pixels 255 -> F(0,0) = 1016, all AC = 0; all pixels 1 -> F(0,0) = −1016, AC = 0.
- Pixel(0,0) = 255, rest 128 -> F(0,0) = 16; every F(u,v) within ±1 of 31.75·c(u)c(v)·cos(uπ/16)·cos(vπ/16).
- Two back-to-back blocks, `in_sof` on the first only -> 16 consecutive output beats; sof on beat 0 only; sob on beats 0/8; eob on beats 7/15; beat 0 at T+3 after each block's 8th row.
- Reset asserted at row 4, then a fresh block after release -> only the fresh block is emitted, with correct values.
- Random blocks with pixels 1..255 and random 1–36 cycle gaps, chained into `dct_it_matrix` -> every reconstructed pixel within ±2 of input, and sideband order identical.
